// File: rtl/msg_stream_pkg.sv
`default_nettype none
// ---------------------------------------------------------------
// msg_stream_pkg : shared FSM encoding and message constants (rev 1.0)
// ---------------------------------------------------------------
package msg_stream_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SEND  = 2'd1,
    S_GAP   = 2'd2,
    S_PAUSE = 2'd3
  } state_t;

  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam int         MAX_LEN     = 9;
  localparam logic [3:0] MSG_LEN [4] = '{4'd9, 4'd7, 4'd6, 4'd3};

endpackage
`default_nettype wire

// File: rtl/msg_rom.sv
`default_nettype none
// ---------------------------------------------------------------
// msg_rom : combinational character/length lookup (rev 1.0)
// ---------------------------------------------------------------
module msg_rom
  import msg_stream_pkg::*;
(
  input  logic [1:0] sel,
  input  logic [3:0] idx,
  output logic [7:0] data,
  output logic [3:0] len
);

  // Texts are left-justified in a MAX_LEN field; padding is never emitted
  localparam logic [8*MAX_LEN-1:0] MSG_TXT [4] = '{
    "Guatemala", "Quetzal  ", "Zacapa   ", "Soy      "
  };

  logic [3:0] idx_c;
  int         pos;

  always_comb begin
    idx_c = (int'(idx) < MAX_LEN) ? idx : 4'd0;
    pos   = 8 * (MAX_LEN - 1 - int'(idx_c));
    data  = MSG_TXT[sel][pos +: 8];
    len   = MSG_LEN[sel];
  end

endmodule
`default_nettype wire

// File: rtl/msg_streamer.sv
`default_nettype none
// ---------------------------------------------------------------
// msg_streamer : valid/ready ASCII message generator (rev 1.0)
// ---------------------------------------------------------------
module msg_streamer
  import msg_stream_pkg::*;
#(
  parameter int NUM_MSG = 4,
  parameter int GAP_LEN = 0,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             start,
  input  logic             abort,
  input  logic             mode,
  input  logic [1:0]       sel,
  input  logic             q_ready,
  output logic [7:0]       q_out,
  output logic             q_valid,
  output logic             q_last,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] msg_count
);

  localparam logic [3:0] GAP_LAST  = (GAP_LEN > 0) ? 4'(GAP_LEN - 1) : 4'd0;
  localparam state_t     AFTER_MSG = (GAP_LEN > 0) ? S_GAP : S_SEND;

  state_t           state, ret_state, nstate, nret, nxt;
  logic [1:0]       sel_l, nsel;
  logic             mode_l, nmode;
  logic [3:0]       idx, nidx, gap_cnt, ngap;
  logic [CNT_W-1:0] ncount;
  logic             ndone, nerr, hs, beat_done;
  logic [7:0]       rom_data;
  logic [3:0]       rom_len;

  // Looked up at the next-cycle position so q_out can be registered
  msg_rom u_rom (
    .sel  (nsel),
    .idx  (nidx),
    .data (rom_data),
    .len  (rom_len)
  );

  always_comb begin
    nstate    = state;
    nret      = ret_state;
    nxt       = state;
    nsel      = sel_l;
    nmode     = mode_l;
    nidx      = idx;
    ngap      = gap_cnt;
    ncount    = msg_count;
    ndone     = 1'b0;
    nerr      = 1'b0;
    beat_done = 1'b0;
    hs        = q_valid & q_ready;

    case (state)
      S_IDLE: begin
        if (start && en && !abort) begin
          if (int'(sel) < NUM_MSG) begin
            nstate = S_SEND;
            nsel   = sel;
            nmode  = mode;
            nidx   = 4'd0;
          end else begin
            nerr = 1'b1;
          end
        end
      end
      S_SEND: begin
        if (hs) begin
          beat_done = 1'b1;
          if (q_last) begin
            ncount = msg_count + CNT_W'(1);
            nidx   = 4'd0;
            ngap   = 4'd0;
            if (!mode_l) begin
              nxt   = S_IDLE;
              ndone = 1'b1;
            end else begin
              nxt = AFTER_MSG;
            end
          end else begin
            nidx = idx + 4'd1;
            nxt  = S_SEND;
          end
        end
      end
      S_GAP: begin
        if (hs) begin
          beat_done = 1'b1;
          if (gap_cnt == GAP_LAST) begin
            nxt  = S_SEND;
            nidx = 4'd0;
          end else begin
            ngap = gap_cnt + 4'd1;
            nxt  = S_GAP;
          end
        end
      end
      S_PAUSE: begin
        if (en) nstate = ret_state;
      end
      default: nstate = S_IDLE;
    endcase

    // Enable is only honoured at beat boundaries; remember where to resume
    if (beat_done) begin
      if (nxt != S_IDLE && !en) begin
        nstate = S_PAUSE;
        nret   = nxt;
      end else begin
        nstate = nxt;
      end
    end

    if (abort && state != S_IDLE) begin
      nstate = S_IDLE;
      ndone  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      ret_state <= S_SEND;
      sel_l     <= 2'd0;
      mode_l    <= 1'b0;
      idx       <= 4'd0;
      gap_cnt   <= 4'd0;
      msg_count <= '0;
      q_out     <= 8'h00;
      q_valid   <= 1'b0;
      q_last    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= nstate;
      ret_state <= nret;
      sel_l     <= nsel;
      mode_l    <= nmode;
      idx       <= nidx;
      gap_cnt   <= ngap;
      msg_count <= ncount;
      q_valid   <= (nstate == S_SEND) || (nstate == S_GAP);
      q_out     <= (nstate == S_SEND) ? rom_data :
                   (nstate == S_GAP)  ? ASCII_SPACE : 8'h00;
      q_last    <= (nstate == S_SEND) && (nidx == rom_len - 4'd1);
      busy      <= (nstate != S_IDLE);
      done      <= ndone;
      err       <= nerr;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_msg_streamer.sv
`default_nettype none
// ---------------------------------------------------------------
// tb_msg_streamer : two configurations vs. a byte-stream reference model (rev 1.0)
// ---------------------------------------------------------------
module tb_msg_streamer;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       en, start, abort, mode, q_ready;
  logic [1:0] sel;

  logic [7:0] q_out     [2];
  logic       q_valid   [2];
  logic       q_last    [2];
  logic       busy      [2];
  logic       done      [2];
  logic       err       [2];
  logic [7:0] msg_count [2];

  always #5 clk = ~clk;

  msg_streamer #(.NUM_MSG(4), .GAP_LEN(2), .CNT_W(8)) dut0 (
    .clk(clk), .reset(reset_n), .en(en), .start(start), .abort(abort),
    .mode(mode), .sel(sel), .q_ready(q_ready), .q_out(q_out[0]),
    .q_valid(q_valid[0]), .q_last(q_last[0]), .busy(busy[0]),
    .done(done[0]), .err(err[0]), .msg_count(msg_count[0])
  );

  msg_streamer #(.NUM_MSG(3), .GAP_LEN(0), .CNT_W(8)) dut1 (
    .clk(clk), .reset(reset_n), .en(en), .start(start), .abort(abort),
    .mode(mode), .sel(sel), .q_ready(q_ready), .q_out(q_out[1]),
    .q_valid(q_valid[1]), .q_last(q_last[1]), .busy(busy[1]),
    .done(done[1]), .err(err[1]), .msg_count(msg_count[1])
  );

  // Reference: each instance walks a repeating pattern "message + gap spaces"
  string msgs [4] = '{"Guatemala", "Quetzal", "Zacapa", "Soy"};
  int    num_msg [2] = '{4, 3};
  int    gap_len [2] = '{2, 0};
  int    act [2], oneshot [2], msel [2], pos [2], paused [2], cnt [2];
  int    edone [2], eerr [2];
  int    checks = 0;
  int    errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      act[k] = 0; oneshot[k] = 0; msel[k] = 0; pos[k] = 0;
      paused[k] = 0; cnt[k] = 0; edone[k] = 0; eerr[k] = 0;
    end
  endtask

  task automatic model_step(input int k);
    int len, period;
    edone[k] = 0;
    eerr[k]  = 0;
    if (act[k] != 0) begin
      len    = msgs[msel[k]].len();
      period = (oneshot[k] != 0) ? len : len + gap_len[k];
      if (paused[k] != 0) begin
        if (en) paused[k] = 0;
      end else if (q_ready) begin
        if (pos[k] == len - 1) cnt[k] = (cnt[k] + 1) % 256;
        if (oneshot[k] != 0 && pos[k] == len - 1) begin
          act[k]   = 0;
          edone[k] = abort ? 0 : 1;
        end else begin
          pos[k] = (pos[k] + 1) % period;
          if (!en) paused[k] = 1;
        end
      end
      if (abort) begin
        act[k]    = 0;
        paused[k] = 0;
      end
    end else if (start && en && !abort) begin
      if (int'(sel) < num_msg[k]) begin
        act[k]     = 1;
        oneshot[k] = mode ? 0 : 1;
        msel[k]    = int'(sel);
        pos[k]     = 0;
        paused[k]  = 0;
      end else begin
        eerr[k] = 1;
      end
    end
  endtask

  task automatic check_outputs(input int k);
    int         len;
    int         v;
    logic [7:0] eb;
    len = msgs[msel[k]].len();
    v   = (act[k] != 0 && paused[k] == 0) ? 1 : 0;
    eb  = (pos[k] < len) ? msgs[msel[k]][pos[k]] : 8'h20;
    check($sformatf("u%0d.q_valid", k), q_valid[k], v);
    check($sformatf("u%0d.q_last", k), q_last[k], (v != 0 && pos[k] == len - 1) ? 1 : 0);
    check($sformatf("u%0d.busy", k), busy[k], act[k]);
    check($sformatf("u%0d.done", k), done[k], edone[k]);
    check($sformatf("u%0d.err", k), err[k], eerr[k]);
    check($sformatf("u%0d.msg_count", k), msg_count[k], cnt[k]);
    if (v != 0) check($sformatf("u%0d.q_out", k), q_out[k], eb);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
    check_outputs(0);
    check_outputs(1);
  endtask

  task automatic go(input logic [1:0] s, input logic m);
    sel   = s;
    mode  = m;
    start = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  task automatic async_reset();
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    model_reset();
    check("rst.q_out0", q_out[0], 8'h00);
    check("rst.q_out1", q_out[1], 8'h00);
    check_outputs(0);
    check_outputs(1);
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    en = 1'b1; start = 1'b0; abort = 1'b0; mode = 1'b0; sel = 2'd0; q_ready = 1'b1;
    reset_n = 1'b1;
    async_reset();

    // One-shot "Guatemala" with no backpressure
    go(2'd0, 1'b0);
    repeat (12) cycle();
    check("oneshot_count", msg_count[0], 8'd1);

    // Same message with q_ready low in cycles 4..6
    go(2'd0, 1'b0);
    for (int c = 1; c <= 13; c++) begin
      q_ready = (c < 4 || c > 6);
      cycle();
    end
    q_ready = 1'b1;

    // Loop "Soy" with gap; a mid-stream start is ignored; then abort
    go(2'd3, 1'b1);
    repeat (8) cycle();
    sel = 2'd0; start = 1'b1; cycle(); start = 1'b0;
    repeat (6) cycle();
    abort = 1'b1; cycle(); abort = 1'b0;
    repeat (3) cycle();

    // start and abort together in IDLE
    sel = 2'd1; start = 1'b1; abort = 1'b1; cycle();
    start = 1'b0; abort = 1'b0; cycle();
    check("start_abort_idle", busy[0], 1'b0);

    // Pause over the idx-2 handshake of "Zacapa"
    go(2'd2, 1'b0);
    for (int c = 1; c <= 12; c++) begin
      en = !(c >= 3 && c <= 5);
      cycle();
    end
    en = 1'b1;

    // Reset in the middle of "Quetzal", then restart it
    go(2'd1, 1'b0);
    repeat (3) cycle();
    async_reset();
    go(2'd1, 1'b0);
    check("first_after_reset", q_out[0], 8'h51);
    repeat (10) cycle();

    // Randomised traffic
    for (int i = 0; i < 4000; i++) begin
      en      = ($urandom_range(0, 9) != 0);
      start   = ($urandom_range(0, 7) == 0);
      abort   = ($urandom_range(0, 39) == 0);
      mode    = 1'($urandom_range(0, 1));
      sel     = 2'($urandom_range(0, 3));
      q_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    en = 1'b1; start = 1'b0; abort = 1'b1; q_ready = 1'b1;
    cycle();
    abort = 1'b0;
    repeat (5) cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
